// File: rtl/apb_rr_master.sv
// Round-robin arbiter plus single-transfer APB master shared by N_REQ requesters.
// One command per grant; done pulses the owner one cycle after completion or timeout.
module apb_rr_master #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_W-1:0]       PADDR,
    output logic [DATA_W-1:0]       PWDATA,
    input  logic                    PREADY,
    input  logic [DATA_W-1:0]       PRDATA,
    input  logic                    PSLVERR
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0] NQ = (PW+1)'(N_REQ);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]           state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        pick;
    logic [PW-1:0]        off;
    logic [PW-1:0]        nxt_ptr;
    logic [PW:0]          sum;
    logic [TW-1:0]        tcnt;
    logic [N_REQ-1:0]     elig;
    logic [N_REQ-1:0]     rot;
    logic [2*N_REQ-1:0]   dbl;
    logic                 found;
    logic                 sel_wr;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 finish;

    assign elig    = req & ~done;
    assign PSEL    = (state == SETUP) || (state == ACCESS);
    assign PENABLE = (state == ACCESS);

    // rotate so bit 0 is the requester at ptr; first set bit wins
    assign dbl = {elig, elig} >> ptr;
    assign rot = dbl[N_REQ-1:0];

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = PW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NQ) sum = sum - NQ;
        pick = sum[PW-1:0];
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == PW'(k)) begin
                sel_wr    = req_wr[k];
                sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign nxt_ptr = (owner == PW'(N_REQ-1)) ? '0 : owner + PW'(1);
    assign finish  = PREADY || (tcnt == TW'(TIMEOUT-1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            tcnt      <= '0;
            gnt       <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= SETUP;
                        owner  <= pick;
                        gnt    <= N_REQ'(1) << pick;
                        PWRITE <= sel_wr;
                        PADDR  <= sel_addr;
                        PWDATA <= sel_wdata;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    tcnt  <= '0;
                end
                ACCESS: begin
                    if (finish) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        done    <= gnt;
                        ptr     <= nxt_ptr;
                        rsp_err <= PREADY ? PSLVERR : 1'b1;
                        if (PREADY && !PWRITE) rsp_rdata <= PRDATA;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and APB protocol.
module tb_apb_rr_master;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [N-1:0]    req, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic            PREADY;
    logic [DW-1:0]   PRDATA;
    logic            PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_rr_master #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic set_cmd(input int i, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]            = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        tick(); tick();
        total++;
        if ({gnt, done, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got psel=%b gnt=%b done=%b paddr=%h rdata=%h want all 0",
                     PSEL, gnt, done, PADDR, rsp_rdata);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_write();
        req[0] = 1'b1;
        set_cmd(0, 1'b1, 32'h12, 32'hDEADBEEF);
        PREADY = 1'b1;
        tick();
        total++;
        if ({PSEL, PENABLE, gnt} !== {2'b10, 4'b0001}) begin
            bad++;
            $display("FAIL wr_setup: got sel/en/gnt=%b%b/%b want 10/0001", PSEL, PENABLE, gnt);
        end
        total++;
        if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h12, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wr_bus: got %b %h %h want 1 00000012 deadbeef", PWRITE, PADDR, PWDATA);
        end
        tick();
        total++;
        if ({PSEL, PENABLE, done} !== {2'b11, 4'b0000}) begin
            bad++;
            $display("FAIL wr_access: got sel/en/done=%b%b/%b want 11/0000", PSEL, PENABLE, done);
        end
        tick();
        total++;
        if ({PSEL, PENABLE, gnt, done, rsp_err} !== {2'b00, 4'b0000, 4'b0001, 1'b0}) begin
            bad++;
            $display("FAIL wr_done: got sel/en/gnt/done/err=%b%b/%b/%b/%b want 00/0000/0001/0",
                     PSEL, PENABLE, gnt, done, rsp_err);
        end
        total++;
        if (rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL wr_rdata_hold: got %h want 00000000", rsp_rdata);
        end
        req = '0;
        tick();
        total++;
        if ({done, PSEL} !== 5'b0) begin
            bad++;
            $display("FAIL wr_single_pulse: got done=%b psel=%b want 0000 0", done, PSEL);
        end
    endtask

    task automatic test_read_wait();
        req[0] = 1'b1;
        set_cmd(0, 1'b0, 32'h15, 32'h0);
        PREADY = 1'b0;
        tick();
        total++;
        if ({PSEL, PENABLE, gnt, PWRITE, PADDR} !== {2'b10, 4'b0001, 1'b0, 32'h15}) begin
            bad++;
            $display("FAIL rd_setup: got %b%b %b %b %h want 10 0001 0 00000015",
                     PSEL, PENABLE, gnt, PWRITE, PADDR);
        end
        set_cmd(0, 1'b1, 32'hFFFF_FFF0, 32'h1);
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({PENABLE, PWRITE, PADDR, done} !== {2'b10, 32'h15, 4'b0}) begin
                bad++;
                $display("FAIL rd_wait: cycle %0d got en=%b wr=%b paddr=%h done=%b want 1 0 00000015 0000",
                         k, PENABLE, PWRITE, PADDR, done);
            end
            if (k < 3) tick();
        end
        PREADY = 1'b1;
        PRDATA = 32'hDABBCAFE;
        tick();
        total++;
        if ({done, rsp_err, PSEL, rsp_rdata} !== {4'b0001, 2'b00, 32'hDABBCAFE}) begin
            bad++;
            $display("FAIL rd_done: got done=%b err=%b psel=%b rdata=%h want 0001 0 0 dabbcafe",
                     done, rsp_err, PSEL, rsp_rdata);
        end
        req = '0; PREADY = 1'b0; PRDATA = '0;
        tick();
    endtask

    task automatic test_rr();
        int ng, nd;
        int cnt [N];
        logic [N-1:0] exp;
        PRESET = 1'b1; tick(); PRESET = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_cmd(i, 1'b0, 32'(i * 4), 32'h0);
            cnt[i] = 0;
        end
        req = '1; PREADY = 1'b1; PRDATA = 32'h1234_5678;
        ng = 0; nd = 0;
        for (int c = 0; c < 200 && nd < 8; c++) begin
            tick();
            if (PSEL && !PENABLE) begin
                exp = N'(1) << (ng % N);
                total++;
                if (gnt !== exp) begin
                    bad++;
                    $display("FAIL rr_order: grant %0d got %b want %b", ng, gnt, exp);
                end
                ng++;
                if (ng == 8) req = '0;
            end
            if (done != 0) begin
                nd++;
                for (int i = 0; i < N; i++) if (done[i]) cnt[i]++;
            end
            total++;
            if ((gnt & done) !== '0) begin
                bad++;
                $display("FAIL rr_gnt_done_overlap: got gnt=%b done=%b want disjoint", gnt, done);
            end
        end
        total++;
        if (nd != 8) begin
            bad++;
            $display("FAIL rr_bound: got %0d completions want 8", nd);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (cnt[i] != 2) begin
                bad++;
                $display("FAIL rr_fair: requester %0d got %0d dones want 2", i, cnt[i]);
            end
        end
        PREADY = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        req[1] = 1'b1;
        set_cmd(1, 1'b1, 32'h44, 32'h0BAD_F00D);
        PREADY = 1'b0;
        n = 0; got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (done != 0) got = 1'b1;
            else if (PENABLE) n++;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL to_bound: got no done within 60 cycles want done");
        end
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL to_cycles: got %0d access cycles want %0d", n, TO);
        end
        total++;
        if ({done, rsp_err, PSEL, PENABLE, gnt} !== {4'b0010, 3'b100, 4'b0000}) begin
            bad++;
            $display("FAIL to_abort: got done=%b err=%b sel=%b en=%b gnt=%b want 0010 1 0 0 0000",
                     done, rsp_err, PSEL, PENABLE, gnt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_slverr();
        bit got;
        req[2] = 1'b1;
        set_cmd(2, 1'b0, 32'h40, 32'h0);
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5A5A_0001;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (done != 0) got = 1'b1;
        end
        total++;
        if ({got, done, rsp_err, rsp_rdata} !== {1'b1, 4'b0100, 1'b1, 32'h5A5A_0001}) begin
            bad++;
            $display("FAIL slverr: got seen=%b done=%b err=%b rdata=%h want 1 0100 1 5a5a0001",
                     got, done, rsp_err, rsp_rdata);
        end
        req = '0; PSLVERR = 1'b0; PREADY = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        set_cmd(3, 1'b0, 32'h30, 32'h0);
        PREADY = 1'b0;
        tick();
        total++;
        if ({PSEL, gnt} !== {1'b1, 4'b1000}) begin
            bad++;
            $display("FAIL rm_pre_grant: got sel=%b gnt=%b want 1 1000", PSEL, gnt);
        end
        tick();
        PRESET = 1'b1;
        req = 4'b1100;
        set_cmd(2, 1'b1, 32'h20, 32'hCAFE_0002);
        tick();
        total++;
        if ({gnt, done, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            bad++;
            $display("FAIL rm_outputs: got sel=%b en=%b gnt=%b done=%b paddr=%h rdata=%h want all 0",
                     PSEL, PENABLE, gnt, done, PADDR, rsp_rdata);
        end
        PRESET = 1'b0;
        PREADY = 1'b1;
        tick();
        total++;
        if ({PSEL, PENABLE, gnt, done, PADDR} !== {2'b10, 4'b0100, 4'b0000, 32'h20}) begin
            bad++;
            $display("FAIL rm_ptr_reset: got %b%b gnt=%b done=%b paddr=%h want 10 0100 0000 00000020",
                     PSEL, PENABLE, gnt, done, PADDR);
        end
        tick(); tick();
        total++;
        if (done !== 4'b0100) begin
            bad++;
            $display("FAIL rm_done2: got %b want 0100", done);
        end
        req[2] = 1'b0;
        tick();
        total++;
        if ({PSEL, PENABLE, gnt} !== {2'b10, 4'b1000}) begin
            bad++;
            $display("FAIL rm_next3: got %b%b gnt=%b want 10 1000", PSEL, PENABLE, gnt);
        end
        req = '0;
        tick(); tick();
        total++;
        if (done !== 4'b1000) begin
            bad++;
            $display("FAIL rm_drop_after_grant: got done=%b want 1000", done);
        end
        PREADY = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        req = 4'b0001;
        set_cmd(0, 1'b0, 32'h50, 32'h0);
        PREADY = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL wd_grant0: got %b want 0001", gnt);
        end
        req = 4'b0010;
        set_cmd(1, 1'b1, 32'h60, 32'h6);
        tick(); tick();
        req = '0;
        PREADY = 1'b1;
        tick();
        total++;
        if (done !== 4'b0001) begin
            bad++;
            $display("FAIL wd_done0: got %b want 0001", done);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({PSEL, gnt, done} !== 9'b0) begin
                bad++;
                $display("FAIL wd_no_xfer: cycle %0d got sel=%b gnt=%b done=%b want 0", c, PSEL, gnt, done);
            end
        end
        PREADY = 1'b0;
    endtask

    task automatic test_random();
        int ph, owner, waited, mptr, idx;
        bit snap_wr, dead, found;
        logic [AW-1:0] snap_a;
        logic [DW-1:0] snap_d, exp_rd;
        logic [N-1:0] exp_done, nxt_done, elig, exp_gnt;
        logic exp_err, nxt_err;
        PRESET = 1'b1; req = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick();
        PRESET = 1'b0;
        ph = 0; owner = 0; waited = 0; mptr = 0; dead = 1'b0;
        snap_wr = 1'b0; snap_a = '0; snap_d = '0;
        exp_rd = '0; exp_done = '0; exp_err = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (ph != 0 && i == owner) begin
                    set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if (exp_done[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(0, 3) == 0);
            PREADY  = ($urandom_range(0, 1) == 0);
            nxt_done = '0;
            nxt_err  = exp_err;
            case (ph)
                0: begin
                    elig  = req & ~exp_done;
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        idx = (mptr + k) % N;
                        if (!found && elig[idx]) begin
                            found = 1'b1;
                            owner = idx;
                        end
                    end
                    if (found) begin
                        snap_wr = req_wr[owner];
                        snap_a  = req_addr[owner*AW +: AW];
                        snap_d  = req_wdata[owner*DW +: DW];
                        ph = 1;
                    end
                end
                1: begin
                    ph = 2;
                    waited = 0;
                    dead = ($urandom_range(0, 5) == 0);
                end
                default: begin
                    if (dead) PREADY = 1'b0;
                    if (PREADY) begin
                        nxt_done = N'(1) << owner;
                        nxt_err  = PSLVERR;
                        if (!snap_wr) exp_rd = PRDATA;
                        ph = 0;
                        mptr = (owner + 1) % N;
                    end else begin
                        waited++;
                        if (waited == TO) begin
                            nxt_done = N'(1) << owner;
                            nxt_err  = 1'b1;
                            ph = 0;
                            mptr = (owner + 1) % N;
                        end
                    end
                end
            endcase
            exp_done = nxt_done;
            exp_err  = nxt_err;
            tick();
            exp_gnt = (ph != 0) ? N'(1) << owner : '0;
            total++;
            if ({PSEL, PENABLE, gnt, done} !== {ph != 0, ph == 2, exp_gnt, exp_done}) begin
                bad++;
                $display("FAIL rnd_ctrl: cyc %0d got sel=%b en=%b gnt=%b done=%b want %b %b %b %b",
                         cyc, PSEL, PENABLE, gnt, done, ph != 0, ph == 2, exp_gnt, exp_done);
            end
            total++;
            if (rsp_rdata !== exp_rd) begin
                bad++;
                $display("FAIL rnd_rdata: cyc %0d got %h want %h", cyc, rsp_rdata, exp_rd);
            end
            if (exp_done != 0) begin
                total++;
                if (rsp_err !== exp_err) begin
                    bad++;
                    $display("FAIL rnd_err: cyc %0d got %b want %b", cyc, rsp_err, exp_err);
                end
            end
            if (ph != 0) begin
                total++;
                if ({PWRITE, PADDR, PWDATA} !== {snap_wr, snap_a, snap_d}) begin
                    bad++;
                    $display("FAIL rnd_bus: cyc %0d got %b %h %h want %b %h %h",
                             cyc, PWRITE, PADDR, PWDATA, snap_wr, snap_a, snap_d);
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_rr();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
